// File: rtl/pcm_out_reader_pkg.sv
// Shared definitions for the PCM output reader: region code, frame length,
// channel codes, FSM state encodings and the FIFO word layout.
package pcm_out_reader_pkg;

  localparam logic [1:0]  PCM_REGION    = 2'b01;
  localparam int unsigned PCM_FRAME_LEN = 576;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic        ch;
    logic [15:0] data;
  } pcm_word_t;

  function automatic logic [12:0] pcm_addr(input logic [1:0] region,
                                           input logic       ch,
                                           input logic [9:0] idx);
    return {region, ch, idx};
  endfunction

endpackage

// File: rtl/pcm_out_reader_fifo.sv
// Synchronous FIFO with registered head (Dout/Valid); Count includes the head entry.
module pcm_fifo
  import pcm_out_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = $bits(pcm_word_t)
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Push,
  input  logic [WIDTH-1:0]         Din,
  input  logic                     Pop,
  output logic [WIDTH-1:0]         Dout,
  output logic                     Valid,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count_n;
  logic             do_push, do_pop;

  assign Full     = (Count == CW'(DEPTH));
  assign Empty    = (Count == '0);
  assign do_pop   = Pop && !Empty;
  assign do_push  = Push && (!Full || do_pop);
  assign rd_ptr_n = rd_ptr + PW'(do_pop);
  assign count_n  = Count + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= Din;
  end

  // Head is preloaded from next-cycle state; a push landing on the new head slot bypasses the RAM.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Dout   <= '0;
      Valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_n;
      Count  <= count_n;
      Valid  <= (count_n != '0);
      if (count_n != '0)
        Dout <= (do_push && (wr_ptr == rd_ptr_n)) ? Din : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/pcm_out_reader.sv
// Streams the PCM granule from work RAM to a valid/ready sample port.
// Build option PCMOUT_CLR_EN: each read is followed by a zeroing write to the same address.
module pcm_out_reader
  import pcm_out_reader_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = PCM_FRAME_LEN,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  RAM_REGION = PCM_REGION
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Stereo,
  output logic        Busy,
  output logic        Done,
  output logic        Ram_CEN,
  output logic        Ram_WEN,
  output logic [12:0] Ram_A,
  output logic [19:0] Ram_D,
  input  logic [19:0] Ram_Q,
  output logic        Pcm_Valid,
  input  logic        Pcm_Ready,
  output logic [15:0] Pcm_Data,
  output logic        Pcm_Ch
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0]  LAST_IDX = 10'(FRAME_LEN - 1);

  logic [1:0]  state, state_n;
  logic        stereo_r;
  logic [9:0]  rd_idx, cur_idx;
  logic        rd_ch, cur_ch, stereo_eff;
  logic        req_rd, q_v, q_ch;
  logic        start_go, issue_rd, issue_wr, credit_ok, last_addr, pop;
  logic [CW:0] occupancy;
  logic [CW-1:0] fifo_count;
  logic        fifo_full, fifo_empty;
  pcm_word_t   fifo_din, fifo_dout;
  logic        unused_ram_q_hi;

  assign unused_ram_q_hi = ^Ram_Q[19:16];

  // The first read is issued on the Start edge itself, so the address source switches to idx 0.
  always_comb begin
    start_go   = (state == ST_IDLE) && Start;
    cur_idx    = start_go ? '0 : rd_idx;
    cur_ch     = start_go ? CH_LEFT : rd_ch;
    stereo_eff = start_go ? Stereo : stereo_r;
    occupancy  = (CW+1)'(fifo_count) + (CW+1)'(req_rd) + (CW+1)'(q_v);
    credit_ok  = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
`ifdef PCMOUT_CLR_EN
    issue_wr   = req_rd;
`else
    issue_wr   = 1'b0;
`endif
    issue_rd   = (start_go || (state == ST_READ)) && credit_ok && !issue_wr;
    last_addr  = (cur_idx == LAST_IDX) && (cur_ch || !stereo_eff);
    pop        = Pcm_Valid && Pcm_Ready;

    state_n = state;
    case (state)
      ST_IDLE:  if (start_go) state_n = last_addr ? ST_DRAIN : ST_READ;
      ST_READ:  if (issue_rd && last_addr) state_n = ST_DRAIN;
      ST_DRAIN: if (!req_rd && !q_v && (fifo_empty || (fifo_count == CW'(1) && pop)))
                  state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= ST_IDLE;
      stereo_r <= 1'b0;
      rd_idx   <= '0;
      rd_ch    <= CH_LEFT;
      req_rd   <= 1'b0;
      q_v      <= 1'b0;
      q_ch     <= 1'b0;
      Ram_CEN  <= 1'b1;
      Ram_WEN  <= 1'b1;
      Ram_A    <= '0;
      Ram_D    <= '0;
    end else begin
      state <= state_n;
      if (start_go) stereo_r <= Stereo;
      if (issue_rd) begin
        if (stereo_eff && !cur_ch) begin
          rd_ch  <= CH_RIGHT;
          rd_idx <= cur_idx;
        end else begin
          rd_ch  <= CH_LEFT;
          rd_idx <= cur_idx + 10'd1;
        end
        Ram_A <= pcm_addr(RAM_REGION, cur_ch, cur_idx);
      end
      req_rd  <= issue_rd;
      q_v     <= req_rd;
      q_ch    <= Ram_A[10];
      Ram_CEN <= !(issue_rd || issue_wr);
      Ram_WEN <= !issue_wr;
      Ram_D   <= '0;
    end
  end

  assign Busy = (state != ST_IDLE);
  assign Done = (state == ST_DONE);

  assign fifo_din = '{ch: q_ch, data: Ram_Q[15:0]};

  pcm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pcm_word_t))
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .Push  (q_v),
    .Din   (fifo_din),
    .Pop   (Pcm_Ready),
    .Dout  (fifo_dout),
    .Valid (Pcm_Valid),
    .Count (fifo_count),
    .Full  (fifo_full),
    .Empty (fifo_empty)
  );

  assign Pcm_Data = fifo_dout.data;
  assign Pcm_Ch   = fifo_dout.ch;

endmodule

// File: tb/tb_pcm_out_reader.sv
// Scoreboard bench for pcm_out_reader: RAM model, address/sample queues, Ready patterns, abort via reset.
module tb_pcm_out_reader;

  localparam int FRAME_LEN  = 576;
  localparam int FIFO_DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic        Stereo = 1'b0;
  logic        Busy, Done, Ram_CEN, Ram_WEN;
  logic [12:0] Ram_A;
  logic [19:0] Ram_D;
  logic [19:0] Ram_Q = '0;
  logic        Pcm_Valid;
  logic        Pcm_Ready = 1'b1;
  logic [15:0] Pcm_Data;
  logic        Pcm_Ch;

  pcm_out_reader #(
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RAM_REGION (2'b01)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Stereo    (Stereo),
    .Busy      (Busy),
    .Done      (Done),
    .Ram_CEN   (Ram_CEN),
    .Ram_WEN   (Ram_WEN),
    .Ram_A     (Ram_A),
    .Ram_D     (Ram_D),
    .Ram_Q     (Ram_Q),
    .Pcm_Valid (Pcm_Valid),
    .Pcm_Ready (Pcm_Ready),
    .Pcm_Data  (Pcm_Data),
    .Pcm_Ch    (Pcm_Ch)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sample_of(input logic ch, input int idx);
    return ch ? (16'h8000 | 16'(idx)) : 16'(idx);
  endfunction

  // RAM model: upper nibble holds junk so dropping Ram_Q[19:16] is exercised
  logic [19:0] ram [8192];
  logic        fill_req = 1'b0;

  always @(posedge Clk) begin
    if (fill_req) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        ram[{2'b01, 1'b0, 10'(i)}] <= {4'hA, sample_of(1'b0, i)};
        ram[{2'b01, 1'b1, 10'(i)}] <= {4'h5, sample_of(1'b1, i)};
      end
    end
    if (!Ram_CEN && !Ram_WEN) ram[Ram_A] <= Ram_D;
    Ram_Q <= (!Ram_CEN && Ram_WEN) ? ram[Ram_A] : 20'hDEAD5;
  end

  logic [16:0] exp_q  [$];
  logic [12:0] addr_q [$];
  int  cyc = 0;
  bit  expect_done = 1'b0;
  int  last_xfer_cyc = 0, done_cyc = 0, done_cnt = 0;
  int  rd_cnt = 0, xfer_cnt = 0, start_cyc = 0;
  bit  hold_pend = 1'b0;
  logic [16:0] hold_val = '0;
  bit  prev_rd = 1'b0;
  logic [12:0] last_rd_a = '0;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Rst) begin
      if (Pcm_Valid && Pcm_Ready) begin
        if (exp_q.size() == 0) check("xfer_extra", 1, 0);
        else check("pcm", {Pcm_Ch, Pcm_Data}, exp_q.pop_front());
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (hold_pend) check("hold", {Pcm_Valid, Pcm_Ch, Pcm_Data}, {1'b1, hold_val});
      hold_pend = Pcm_Valid && !Pcm_Ready;
      hold_val  = {Pcm_Ch, Pcm_Data};

`ifdef PCMOUT_CLR_EN
      if (prev_rd) check("clr_follow", {Ram_CEN, Ram_WEN}, 2'b00);
      if (!Ram_CEN && !Ram_WEN) begin
        check("clr_after_rd", prev_rd, 1);
        check("clr_addr", Ram_A, last_rd_a);
        check("clr_data", Ram_D, 0);
      end
`else
      if (!Ram_CEN && !Ram_WEN) check("ro_write", 1, 0);
`endif
      prev_rd = !Ram_CEN && Ram_WEN;
      if (!Ram_CEN && Ram_WEN) begin
        rd_cnt++;
        last_rd_a = Ram_A;
        if (addr_q.size() == 0) check("addr_extra", 1, 0);
        else check("addr", Ram_A, addr_q.pop_front());
        check("outstanding", (rd_cnt - xfer_cnt) <= FIFO_DEPTH, 1);
      end

      if (Done) begin
        if (!expect_done) check("done_unexpected", 1, 0);
        else begin
          check("done_lag", cyc - last_xfer_cyc, 1);
          check("done_left", exp_q.size(), 0);
        end
        done_cnt++;
        done_cyc = cyc;
        expect_done = 1'b0;
      end
    end else begin
      hold_pend = 1'b0;
      prev_rd   = 1'b0;
    end
  end

  // Ready source: mode 0 always ready; mode 1 30% random with 50-cycle stalls
  int rdy_mode = 0;
  int ph = 0;
  always @(posedge Clk) begin
    #1;
    if (rdy_mode == 0) Pcm_Ready = 1'b1;
    else begin
      ph++;
      if (ph % 300 >= 250) begin
        Pcm_Ready = 1'b0;
        if (ph % 300 == 260) check("stall_cen", Ram_CEN, 1);
      end else Pcm_Ready = ($urandom_range(0, 9) < 3);
    end
  end

  task automatic fill_ram();
    @(negedge Clk);
    fill_req = 1'b1;
    @(posedge Clk);
    #1 fill_req = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_busy",  Busy, 0);
    check("rst_done",  Done, 0);
    check("rst_cen",   Ram_CEN, 1);
    check("rst_wen",   Ram_WEN, 1);
    check("rst_a",     Ram_A, 0);
    check("rst_d",     Ram_D, 0);
    check("rst_valid", Pcm_Valid, 0);
    check("rst_data",  Pcm_Data, 0);
    check("rst_ch",    Pcm_Ch, 0);
  endtask

  task automatic start_frame(input bit st);
    for (int i = 0; i < FRAME_LEN; i++) begin
      exp_q.push_back({1'b0, sample_of(1'b0, i)});
      addr_q.push_back({2'b01, 1'b0, 10'(i)});
      if (st) begin
        exp_q.push_back({1'b1, sample_of(1'b1, i)});
        addr_q.push_back({2'b01, 1'b1, 10'(i)});
      end
    end
    xfer_cnt = 0;
    rd_cnt = 0;
    expect_done = 1'b1;
    @(negedge Clk);
    Start = 1'b1;
    Stereo = st;
    start_cyc = cyc;
    @(negedge Clk);
    Start = 1'b0;
    Stereo = 1'b0;
  endtask

  task automatic check_ram_after(input bit st);
    int wrong = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      for (int c = 0; c < (st ? 2 : 1); c++) begin
        logic [19:0] w;
        w = ram[{2'b01, c[0], 10'(i)}];
`ifdef PCMOUT_CLR_EN
        if (w !== 20'h0) wrong++;
`else
        if (w !== {(c == 0) ? 4'hA : 4'h5, sample_of(c[0], i)}) wrong++;
`endif
      end
    end
    check("ram_after", wrong, 0);
  endtask

  task automatic finish_frame(input bit st, input int budget, input bit timed);
    int n = 0;
    int nsamp;
    nsamp = st ? 2 * FRAME_LEN : FRAME_LEN;
    while (expect_done && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (expect_done) begin
      check("done_timeout", 0, 1);
      expect_done = 1'b0;
      exp_q.delete();
      addr_q.delete();
    end
    @(negedge Clk);
    check("frame_xfers", xfer_cnt, nsamp);
    check("frame_reads", rd_cnt, nsamp);
    check("idle_after", {Busy, Ram_CEN, Pcm_Valid}, 3'b010);
`ifndef PCMOUT_CLR_EN
    if (timed) check("frame_cycles", done_cyc - start_cyc, nsamp + 3);
`endif
    check_ram_after(st);
  endtask

  initial begin
    int n;
    int dc;
    fill_ram();
    repeat (2) @(negedge Clk);
    reset_checks();
    Rst = 1'b1;

    // mono, always ready, with first-sample latency
    start_frame(1'b0);
    check("busy_c1", Busy, 1);
    check("cen_c1", Ram_CEN, 0);
    check("addr_c1", Ram_A, 13'h0800);
    @(negedge Clk);
    check("valid_c2", Pcm_Valid, 0);
    @(negedge Clk);
    check("valid_c3", Pcm_Valid, 1);
    finish_frame(1'b0, 5000, 1'b1);

    // stereo, always ready
    fill_ram();
    start_frame(1'b1);
    finish_frame(1'b1, 8000, 1'b1);

    // stereo under random backpressure and long stalls
    fill_ram();
    rdy_mode = 1;
    start_frame(1'b1);
    finish_frame(1'b1, 30000, 1'b0);
    rdy_mode = 0;

    // stray Start while busy, then abort via reset at sample 100
    fill_ram();
    start_frame(1'b0);
    repeat (4) @(negedge Clk);
    Start = 1'b1;
    Stereo = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Stereo = 1'b0;
    n = 0;
    while (xfer_cnt < 100 && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check("reach_100", xfer_cnt >= 100, 1);
    #1 Rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    expect_done = 1'b0;
    dc = done_cnt;
    #1 reset_checks();
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (20) @(negedge Clk);
    check("abort_no_done", done_cnt, dc);
    check("abort_idle", {Busy, Pcm_Valid, Ram_CEN}, 3'b001);

    // a fresh Start replays from idx 0
    fill_ram();
    start_frame(1'b0);
    finish_frame(1'b0, 5000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
